// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Holds op codes, FSM state codes and the default datapath width.
// Imported by muldiv_unit and muldiv_step.
package muldiv_unit_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or restoring divider.
// Latency: purely combinational, the caller registers acc_out.
// Backpressure: none, the caller decides when to advance.
module muldiv_step
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
  always_comb begin
    sum    = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    rem_sh = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, opnd});
    // When ge holds the true difference is below the divisor, so W-bit modular
    // subtraction gives the exact new remainder.
    diff   = rem_sh[WIDTH-1:0] - opnd;
    if (is_div) begin
      acc_out = {(ge ? diff : rem_sh[WIDTH-1:0]), acc_in[WIDTH-2:0], ge};
    end else begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO, plus MTHI/MTLO.
// Latency: mul/div results land WIDTH edges after start; MTHI/MTLO in one edge.
// Backpressure: start is ignored while busy; upstream must stall on busy.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state, state_d;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opnd, a_raw;
  logic               is_div, neg_res, neg_rem, dbz;

  logic               accept_md, accept_mthi, accept_mtlo, last_iter, signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign busy = (state == ST_RUN);

  // Request decode and operand magnitudes for the signed ops.
  always_comb begin
    accept_md   = (state == ST_IDLE) && start && !op[2];
    accept_mthi = (state == ST_IDLE) && start && (op == OP_MTHI);
    accept_mtlo = (state == ST_IDLE) && start && (op == OP_MTLO);
    signed_op   = (op == OP_MULT) || (op == OP_DIV);
    a_mag       = (signed_op && a[WIDTH-1]) ? -a : a;
    b_mag       = (signed_op && b[WIDTH-1]) ? -b : b;
    last_iter   = (state == ST_RUN) && (cnt == LAST);
  end

  // Next-state logic: IDLE -> RUN on an accepted mul/div, back after WIDTH steps.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (accept_md) state_d = ST_RUN;
      ST_RUN:  if (cnt == LAST) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc_in  (acc),
    .opnd    (opnd),
    .acc_out (acc_nxt)
  );

  // Sign fix applied to the final iteration's output in the writeback cycle.
  always_comb begin
    prod_fix = neg_res ? -acc_nxt : acc_nxt;
    quo_fix  = neg_res ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
  end

  // Operand latch, iteration, HI/LO writeback and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      a_raw   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dbz     <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept_md) begin
        cnt     <= '0;
        is_div  <= op[1];
        neg_res <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_rem <= signed_op && a[WIDTH-1];
        dbz     <= op[1] && (b == '0);
        a_raw   <= a;
        if (op[1]) begin
          acc  <= {{WIDTH{1'b0}}, a_mag};
          opnd <= b_mag;
        end else begin
          acc  <= {{WIDTH{1'b0}}, b_mag};
          opnd <= a_mag;
        end
      end else if (state == ST_RUN) begin
        acc <= acc_nxt;
        cnt <= cnt + CW'(1);
        if (last_iter) begin
          done <= 1'b1;
          if (!is_div) begin
            {hi, lo} <= prod_fix;
          end else if (dbz) begin
            // Divide by zero: all-ones quotient, dividend passed through as remainder.
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
      end
      if (accept_mthi) hi <= a;
      if (accept_mtlo) lo <= a;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences, random ops.
// Expected values come from constants and a plain-arithmetic reference model.
// Every wait on the DUT is bounded by a cycle budget.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, busy, done;
  logic [2:0]   op;
  logic [W-1:0] a, b, hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: {hi, lo} from the architectural definition of each op.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sp, sq, sr;
    logic [63:0] r;
    r = 64'd0;
    case (o)
      3'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        r  = sp;
      end
      3'd1: r = {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else begin
          sq = longint'($signed(x)) / longint'($signed(y));
          sr = longint'($signed(x)) % longint'($signed(y));
          r  = {sr[31:0], sq[31:0]};
        end
      end
      3'd3: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else            r = {x % y, x / y};
      end
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Called at a negedge; presents a request for exactly one posedge.
  task automatic pulse_start(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full mul/div transaction: latency, HI/LO hold, done pulse and result.
  task automatic run_mdu(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] exp, input string name);
    logic [31:0] ph, pl;
    int          cycles;
    logic        hold_ok;
    ph = hi; pl = lo; cycles = 0; hold_ok = 1'b1;
    pulse_start(o, x, y);
    while (busy && cycles < 40) begin
      if (hi !== ph || lo !== pl || done !== 1'b0) hold_ok = 1'b0;
      cycles++;
      @(negedge clk);
    end
    check({name, " latency"}, cycles, 32);
    check({name, " hold"}, hold_ok, 1);
    check({name, " done"}, done, 1);
    check({name, " result"}, {hi, lo}, exp);
    @(negedge clk);
    check({name, " done width"}, done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ph, pl, ra, rb;
    logic [2:0]  ro;
    logic [63:0] res;
    int          busy_cnt, done_cnt;
    logic        hold_ok, done_seen;

    vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu max"};
    vecs[1] = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult -3*7"};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2"};
    vecs[3] = '{3'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, "divu 7/2"};
    vecs[4] = '{3'd2, 32'h0000_0123, 32'h0000_0000, 32'h0000_0123, 32'hFFFF_FFFF, "div by 0"};
    vecs[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div ovf"};
    vecs[6] = '{3'd2, 32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FF00, 32'hFFFF_FFFF, "div neg by 0"};
    vecs[7] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult minint sq"};
    vecs[8] = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult -1*1"};
    vecs[9] = '{3'd3, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, "divu 0/5"};

    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // MTHI then MTLO on consecutive edges, then a reserved op.
    start = 1'b1; op = OP_MTHI; a = 32'h0000_0123;
    @(negedge clk);
    check("mthi hi", hi, 32'h123);
    check("mthi lo", lo, 0);
    check("mthi busy", busy, 0);
    op = OP_MTLO; a = 32'h0000_0005;
    @(negedge clk);
    start = 1'b0;
    check("mtlo lo", lo, 32'h5);
    check("mtlo hi", hi, 32'h123);
    check("mtlo busy/done", {busy, done}, 0);
    pulse_start(3'd7, 32'hDEAD_BEEF, 32'h1);
    check("reserved hilo", {hi, lo}, {32'h123, 32'h5});
    check("reserved busy/done", {busy, done}, 0);
    @(negedge clk);
    check("reserved done later", done, 0);

    for (int i = 0; i < 10; i++)
      run_mdu(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, vecs[i].name);

    // Starts and operand changes while busy must not disturb the running op.
    ph = hi; pl = lo; busy_cnt = 0; done_cnt = 0; hold_ok = 1'b1; res = '0;
    pulse_start(OP_MULTU, 32'h1234_5678, 32'h0000_0009);
    for (int k = 1; k <= 40; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        res = {hi, lo};
      end else if (busy && (hi !== ph || lo !== pl)) hold_ok = 1'b0;
      case (k)
        3:  begin start = 1'b1; op = OP_MULT; a = 32'h7; b = 32'h7; end
        4:  start = 1'b0;
        7:  begin start = 1'b1; op = OP_MTHI; a = 32'h5; end
        8:  start = 1'b0;
        12: begin a = $urandom; b = $urandom; end
        default: ;
      endcase
      @(negedge clk);
    end
    check("inflight busy cycles", busy_cnt, 32);
    check("inflight done count", done_cnt, 1);
    check("inflight hold", hold_ok, 1);
    check("inflight result", res, model(3'd1, 32'h1234_5678, 32'h0000_0009));

    // Reset in the middle of a DIVU aborts it without a done pulse.
    pulse_start(OP_DIVU, 32'd1000, 32'd7);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort hi", hi, 0);
    check("abort lo", lo, 0);
    check("abort done", done, 0);
    done_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) done_seen = 1'b1;
      @(negedge clk);
    end
    check("abort no done", done_seen, 0);
    run_mdu(OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, "after reset");

    // Random ops against the reference model, biased towards corner operands.
    for (int i = 0; i < 150; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_mdu(ro, ra, rb, model(ro, ra, rb), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the register file and consumes its two read ports (rd1 → a, rd2 → b).
- Executes MIPS MULT/MULTU/DIV/DIVU over 32 cycles with a start/busy/done handshake, plus single-cycle MTHI/MTLO.
- HI/LO are read combinationally by the writeback mux for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  input  1  single clock, all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on posedge only when busy=0.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved.
- a  input  WIDTH  operand from RF rd1 (rs); dividend/multiplicand; MTHI/MTLO data.
- b  input  WIDTH  operand from RF rd2 (rt); divisor/multiplier.
- busy  output  1  iterative operation in progress.
- done  output  1  one-cycle pulse when HI/LO receive a mul/div result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset values: hi=0, lo=0, busy=0, done=0; FSM state=IDLE, iteration count=0.
- FSM has two states, IDLE and RUN.
- IDLE + start + op∈{0..3}:
  - Latch a, b and op at the edge.
  - Go to RUN with count=0; busy=1 from that edge.
- IDLE + start + op=4: hi←a at that edge; lo unchanged; no busy, no done.
- IDLE + start + op=5: lo←a at that edge; hi unchanged; no busy, no done.
- IDLE + start + op=6/7: ignored, no state change.
- RUN: one iteration per edge.
  - Multiply: shift-add over a 2·WIDTH accumulator.
  - Divide: restoring, one quotient bit per edge.
  - Latency: start sampled at edge E; busy=1 for cycles after E..E+31; at edge E+32 hi/lo written, busy→0, done=1 for exactly one cycle, state→IDLE.
  - Back-to-back ops: a start may be accepted at edge E+33 at the earliest, i.e. while done=1.
- Operand handling:
  - Operands are latched at start; a/b changes during RUN have no effect.
  - Signed ops (MULT, DIV) run on magnitudes with a final sign fix in the writeback cycle.
  - Product sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Magnitude of 0x80000000 is taken as unsigned 0x80000000, so no overflow.
- Results:
  - MULT/MULTU: {hi,lo} = full 64-bit product.
  - DIV/DIVU: lo = quotient, hi = remainder.
- Divide by zero (DIV or DIVU): lo=0xFFFFFFFF, hi=a. Still takes the full 32 cycles and pulses done.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- While busy=1, start is ignored for every op, including MTHI/MTLO. There is no queueing; the upstream stage must stall on busy.
- hi/lo hold their previous values during RUN and change only at the completion edge.
- rst has priority over everything, including mid-RUN: the operation is aborted and registers return to reset values next cycle, with no done pulse.
- done is never asserted for MTHI/MTLO or reserved ops.

Decomposition:
- Shared package: op encodings (OP_MULT..OP_MTLO), FSM state encodings (ST_IDLE, ST_RUN), WIDTH default.
- One sub-module: muldiv_step, a combinational single-iteration step.
  - Multiply mode: conditional add plus shift.
  - Divide mode: trial subtract plus shift-in of the quotient bit.
- muldiv_unit owns the FSM, counter, operand and sign latches, and the final sign fix.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start at edge E → busy=1 for 32 cycles; at E+32 hi=0xFFFFFFFE, lo=0x00000001, done=1 for one cycle.
- MULT a=0xFFFFFFFD (-3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=7, b=2 → lo=3, hi=1.
- DIV a=0x00000123, b=0 → lo=0xFFFFFFFF, hi=0x00000123 after 32 cycles, done pulses. Then DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MULTU in flight:
  - Issue start MULT and start MTHI 0x5 on cycles 3 and 7 → both ignored; hi/lo unchanged until completion; single done.
  - Also: changing a/b mid-run does not alter the result.
- rst=1 at cycle 10 of a DIVU → next cycle busy=0, hi=0, lo=0, done stays 0. A new start after rst is accepted normally.
- MTHI a=0x00000123, then MTLO a=0x5 on the next cycle → hi=0x123 after the first edge, lo=0x5 after the second; busy and done stay 0. Reserved op=7 with start → no change.
